// File: rtl/spi_txn_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter_if
// Bundles the two requester channels and the SPI master-core control channel
// that the transaction arbiter sits between.
//
//   Requester side : req0/1, slv0/1, dtf0/1, wdata0/1  (into arbiter)
//                    ack0/1, err0/1, rdata             (out of arbiter)
//   Master side    : m_start, m_slave, m_dtf, m_wdata  (out of arbiter)
//                    m_done, m_rdata                   (into arbiter)
//   Status         : busy, owner                       (out of arbiter)
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding environment (requesters plus the SPI core)
// ---------------------------------------------------------------------------
interface spi_txn_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic [1:0]        slv0;
  logic [1:0]        slv1;
  logic [1:0]        dtf0;
  logic [1:0]        dtf1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata;

  logic              m_start;
  logic [1:0]        m_slave;
  logic [1:0]        m_dtf;
  logic [DATA_W-1:0] m_wdata;
  logic              m_done;
  logic [DATA_W-1:0] m_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  req0, req1, slv0, slv1, dtf0, dtf1, wdata0, wdata1,
    input  m_done, m_rdata,
    output ack0, ack1, err0, err1, rdata,
    output m_start, m_slave, m_dtf, m_wdata,
    output busy, owner
  );

  modport master (
    output req0, req1, slv0, slv1, dtf0, dtf1, wdata0, wdata1,
    output m_done, m_rdata,
    input  ack0, ack1, err0, err1, rdata,
    input  m_start, m_slave, m_dtf, m_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter
// Round-robin arbiter/sequencer that shares one SPI master core between two
// requesters. One transaction at a time: grant, program slave code / transfer
// mode / write byte, pulse m_start, wait for m_done (or time out), return the
// received byte with an ack (or an err), then hold slave selects idle for a
// fixed gap before accepting the next request.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - spi_txn_arbiter_if.slave: requester channels, master-core
//          control channel, busy/owner status (all outputs registered)
//
// Parameters:
//   DATA_W     - transfer byte width
//   GAP_CYCLES - idle cycles between transactions (>= 1)
//   TIMEOUT    - WAIT cycles before abort (>= 2, fits 8 bits)
// ---------------------------------------------------------------------------
module spi_txn_arbiter #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input logic              clk,
  input logic              rst,
  spi_txn_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // One counter serves both the WAIT timeout and the GAP length, so size it
  // for whichever is larger.
  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              m_start_reg;
  logic [1:0]        m_slave_reg;
  logic [1:0]        m_dtf_reg;
  logic [DATA_W-1:0] m_wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        ack_reg;
  logic [1:0]        err_reg;
  logic              busy_reg;
  logic              owner_reg;

  // Grant selection, only acted upon in IDLE.
  logic              any_req;
  logic              winner;
  logic [1:0]        win_slv;
  logic [1:0]        win_dtf;
  logic [DATA_W-1:0] win_wdata;
  logic              win_valid;

  always_comb begin
    any_req = bus.req0 | bus.req1;
    // A tie goes to the requester that did not own the last grant; with a
    // single request, req0 low means req1 is the one asking.
    if (bus.req0 && bus.req1) begin
      winner = ~owner_reg;
    end else begin
      winner = ~bus.req0;
    end
    win_slv   = winner ? bus.slv1   : bus.slv0;
    win_dtf   = winner ? bus.dtf1   : bus.dtf0;
    win_wdata = winner ? bus.wdata1 : bus.wdata0;
    win_valid = (win_slv == 2'b01) || (win_slv == 2'b10);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      m_start_reg <= 1'b0;
      m_slave_reg <= 2'b00;
      m_dtf_reg   <= 2'b00;
      m_wdata_reg <= '0;
      rdata_reg   <= '0;
      ack_reg     <= 2'b00;
      err_reg     <= 2'b00;
      busy_reg    <= 1'b0;
      owner_reg   <= 1'b1;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      m_start_reg <= 1'b0;
      ack_reg     <= 2'b00;
      err_reg     <= 2'b00;

      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            owner_reg   <= winner;
            m_dtf_reg   <= win_dtf;
            m_wdata_reg <= win_wdata;
            busy_reg    <= 1'b1;
            cnt_reg     <= '0;
            if (win_valid) begin
              m_slave_reg <= win_slv;
              m_start_reg <= 1'b1;
              state_reg   <= ST_START;
            end else begin
              // Bad slave code: never touch the master, report and back off.
              err_reg[winner] <= 1'b1;
              state_reg       <= ST_GAP;
            end
          end
        end

        ST_START: begin
          cnt_reg   <= '0;
          state_reg <= ST_WAIT;
        end

        ST_WAIT: begin
          // m_done wins over a timeout landing in the same cycle.
          if (bus.m_done) begin
            rdata_reg          <= bus.m_rdata;
            ack_reg[owner_reg] <= 1'b1;
            m_slave_reg        <= 2'b00;
            cnt_reg            <= '0;
            state_reg          <= ST_GAP;
          end else if (cnt_reg == TMO_LAST) begin
            err_reg[owner_reg] <= 1'b1;
            m_slave_reg        <= 2'b00;
            cnt_reg            <= '0;
            state_reg          <= ST_GAP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_start = m_start_reg;
  assign bus.m_slave = m_slave_reg;
  assign bus.m_dtf   = m_dtf_reg;
  assign bus.m_wdata = m_wdata_reg;
  assign bus.rdata   = rdata_reg;
  assign bus.ack0    = ack_reg[0];
  assign bus.ack1    = ack_reg[1];
  assign bus.err0    = err_reg[0];
  assign bus.err1    = err_reg[1];
  assign bus.busy    = busy_reg;
  assign bus.owner   = owner_reg;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_arbiter
// Drives two requesters and a simple SPI-core responder into the arbiter.
// Expected outputs come from a transaction-level timeline: for each grant the
// bench works out the winner and the cycle offset of ack/err, and from that
// derives what every output must be in every cycle of the transaction.
// ---------------------------------------------------------------------------
module tb_spi_txn_arbiter;
  localparam int DATA_W = 8;
  localparam int GAP    = 4;
  localparam int TMO    = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_txn_arbiter_if #(.DATA_W(DATA_W)) bus ();

  spi_txn_arbiter #(
    .DATA_W    (DATA_W),
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int txn_no       = 0;

  // Requester model: pending flag plus held request parameters.
  logic       pend [2];
  logic [1:0] pslv [2];
  logic [1:0] pdtf [2];
  logic [7:0] pwd  [2];
  logic       owner_m;
  logic [7:0] exp_rdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    bus.req0   = pend[0];
    bus.req1   = pend[1];
    bus.slv0   = pslv[0];
    bus.slv1   = pslv[1];
    bus.dtf0   = pdtf[0];
    bus.dtf1   = pdtf[1];
    bus.wdata0 = pwd[0];
    bus.wdata1 = pwd[1];
  endtask

  task automatic check_reset_vals(input string ctx);
    check_val({ctx, " m_start"}, 32'(bus.m_start), 32'd0);
    check_val({ctx, " ack0"},    32'(bus.ack0),    32'd0);
    check_val({ctx, " ack1"},    32'(bus.ack1),    32'd0);
    check_val({ctx, " err0"},    32'(bus.err0),    32'd0);
    check_val({ctx, " err1"},    32'(bus.err1),    32'd0);
    check_val({ctx, " busy"},    32'(bus.busy),    32'd0);
    check_val({ctx, " m_slave"}, 32'(bus.m_slave), 32'd0);
    check_val({ctx, " m_dtf"},   32'(bus.m_dtf),   32'd0);
    check_val({ctx, " m_wdata"}, 32'(bus.m_wdata), 32'd0);
    check_val({ctx, " rdata"},   32'(bus.rdata),   32'd0);
    check_val({ctx, " owner"},   32'(bus.owner),   32'd1);
  endtask

  // One transaction from the grant edge to the first IDLE cycle after GAP.
  // resp >= 0 : m_done in WAIT cycle 'resp' (0 = first WAIT cycle)
  // resp <  0 : no m_done (timeout), plus a late m_done inside GAP
  // drop      : winner drops req during WAIT
  // pulse     : idle requester pulses req during GAP
  task automatic run_txn(input int resp, input bit drop, input bit pulse, input logic [7:0] rd);
    int    w;
    int    e;
    int    last;
    bit    valid;
    bit    good;
    string outcome;
    drive_reqs();
    bus.m_rdata = rd;
    if (pend[0] && pend[1]) w = owner_m ? 0 : 1;
    else                    w = pend[0] ? 0 : 1;
    valid = (pslv[w] == 2'b01) || (pslv[w] == 2'b10);
    good  = valid && (resp >= 0);
    if (!valid)       e = 1;
    else if (resp < 0) e = 2 + TMO;
    else              e = 3 + resp;
    last = e + GAP;
    @(posedge clk);
    owner_m = (w == 1);
    for (int k = 1; k <= last; k++) begin
      #1;
      bus.m_done = (good && k == 2 + resp) || (valid && resp < 0 && k == e + 1);
      if (drop && valid && k == 2) pend[w] = 1'b0;
      if (k == e) begin
        pend[w] = 1'b0;
        if (good) exp_rdata = rd;
      end
      drive_reqs();
      if (pulse && !pend[1-w] && k == e + 1) begin
        if (w == 0) bus.req1 = 1'b1;
        else        bus.req0 = 1'b1;
      end
      @(negedge clk);
      check_val("m_start", 32'(bus.m_start), 32'(valid && k == 1));
      check_val("m_slave", 32'(bus.m_slave), 32'((valid && k < e) ? pslv[w] : 2'b00));
      if (valid && k < e) begin
        check_val("m_dtf",   32'(bus.m_dtf),   32'(pdtf[w]));
        check_val("m_wdata", 32'(bus.m_wdata), 32'(pwd[w]));
      end
      check_val("ack0",  32'(bus.ack0),  32'(good  && k == e && w == 0));
      check_val("ack1",  32'(bus.ack1),  32'(good  && k == e && w == 1));
      check_val("err0",  32'(bus.err0),  32'(!good && k == e && w == 0));
      check_val("err1",  32'(bus.err1),  32'(!good && k == e && w == 1));
      check_val("busy",  32'(bus.busy),  32'(k < last));
      check_val("owner", 32'(bus.owner), 32'(owner_m));
      check_val("rdata", 32'(bus.rdata), 32'(exp_rdata));
      if (k < last) @(posedge clk);
    end
    bus.m_done = 1'b0;
    if (!valid)      outcome = "invalid-slave err";
    else if (!good)  outcome = "timeout err";
    else             outcome = "ack";
    $display("[TB] txn %0d: owner=%0d slv=%b resp=%0d drop=%0d pulse=%0d -> %s rdata=%h",
             txn_no, w, pslv[w], resp, drop, pulse, outcome, exp_rdata);
    txn_no++;
  endtask

  task automatic new_request(input int i);
    pend[i] = 1'b1;
    if ($urandom_range(0, 7) == 0) pslv[i] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    else                           pslv[i] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    pdtf[i] = 2'($urandom_range(0, 3));
    pwd[i]  = 8'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0;
      pslv[i] = 2'b00;
      pdtf[i] = 2'b00;
      pwd[i]  = 8'h00;
    end
    owner_m     = 1'b1;
    exp_rdata   = 8'h00;
    bus.m_done  = 1'b0;
    bus.m_rdata = 8'h00;
    drive_reqs();

    // Reset values.
    rst = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single request with a 10-cycle master response.
    pend[0] = 1'b1; pslv[0] = 2'b01; pdtf[0] = 2'b10; pwd[0] = 8'hA5;
    run_txn(9, 1'b0, 1'b0, 8'h3C);

    // Both requesters held: grants must alternate.
    pslv[0] = 2'b01; pdtf[0] = 2'b01; pwd[0] = 8'h11;
    pslv[1] = 2'b10; pdtf[1] = 2'b11; pwd[1] = 8'h22;
    for (int n = 0; n < 4; n++) begin
      pend[0] = 1'b1;
      pend[1] = 1'b1;
      run_txn($urandom_range(0, 6), 1'b0, 1'b0, 8'($urandom));
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // Invalid slave code on requester 1.
    pend[1] = 1'b1; pslv[1] = 2'b11;
    run_txn(0, 1'b0, 1'b0, 8'h00);

    // Timeout with a late m_done inside GAP.
    pend[0] = 1'b1; pslv[0] = 2'b10; pdtf[0] = 2'b00; pwd[0] = 8'h5A;
    run_txn(-1, 1'b0, 1'b0, 8'hEE);

    // m_done in the very last WAIT cycle still acks.
    pend[0] = 1'b1; pslv[0] = 2'b01;
    run_txn(TMO - 1, 1'b0, 1'b0, 8'h77);

    // req0 dropped during WAIT, req1 pulsed during GAP then withdrawn.
    pend[0] = 1'b1; pslv[0] = 2'b01; pwd[0] = 8'hC3;
    run_txn(4, 1'b1, 1'b1, 8'h99);

    // Randomized traffic, with occasional idle stretches.
    for (int n = 0; n < 40; n++) begin
      if (!pend[0] && !pend[1] && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check_val("idle busy",    32'(bus.busy),    32'd0);
          check_val("idle m_start", 32'(bus.m_start), 32'd0);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) new_request(i);
      end
      if (!pend[0] && !pend[1]) new_request(int'($urandom_range(0, 1)));
      run_txn(($urandom_range(0, 7) == 0) ? -1 :
              (($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 12))),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
    end

    // Reset in the middle of WAIT.
    pend[0] = 1'b1; pend[1] = 1'b0; pslv[0] = 2'b10; pdtf[0] = 2'b11; pwd[0] = 8'h3E;
    drive_reqs();
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_val("pre-reset busy", 32'(bus.busy), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_vals("mid-wait reset");
    pend[0] = 1'b0;
    drive_reqs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.m_done  = 1'b1;
    bus.m_rdata = 8'hD4;
    @(posedge clk);
    #1;
    bus.m_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_val("post-reset ack0",  32'(bus.ack0),  32'd0);
      check_val("post-reset err0",  32'(bus.err0),  32'd0);
      check_val("post-reset busy",  32'(bus.busy),  32'd0);
      check_val("post-reset rdata", 32'(bus.rdata), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin transaction arbiter and sequencer sharing the single SPI master core (the block driving sclk/mosi/miso and slave selects ssb1/ssb2) between two requesters. It captures one request at a time, programs the master's slave code, transfer mode (dtf) and write byte, and waits for completion. It then returns the received byte with an ack pulse and enforces a slave-select idle gap before the next transaction. It sits between the requesters and the master core inside the SPI top level.

## Interface
- DATA_W, 8, transfer byte width
- GAP_CYCLES, 4, idle clk cycles between transactions (>=1)
- TIMEOUT, 255, max WAIT cycles before abort (>=2, fits 8 bits)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0, req1  in  1  transaction request, held high until ack/err
- slv0, slv1  in  2  target slave: 2'b01 = ssb1, 2'b10 = ssb2; 00/11 invalid
- dtf0, dtf1  in  2  transfer mode, passed to master unchanged
- wdata0, wdata1  in  DATA_W  byte to transmit
- ack0, ack1  out  1  one-cycle completion pulse
- err0, err1  out  1  one-cycle abort pulse (invalid slave or timeout)
- rdata  out  DATA_W  received byte, valid in the ack cycle, held after
- m_start  out  1  one-cycle start pulse to master
- m_slave  out  2  slave code to master; 2'b00 when not in START/WAIT
- m_dtf  out  2  transfer mode to master
- m_wdata  out  DATA_W  write byte to master
- m_done  in  1  master completion pulse
- m_rdata  in  DATA_W  master received byte, valid with m_done
- busy  out  1  high in every state except IDLE
- owner  out  1  requester index of current/last grant

## Operation
- States: IDLE, START, WAIT, GAP. All outputs registered.
- IDLE: if any req high, grant and register slv/dtf/wdata of the winner into m_slave/m_dtf/m_wdata. Set owner. Go to START. Otherwise stay.
- Arbitration: single request wins. Both high: grant requester != owner (round robin). After reset owner=1, so req0 wins the first tie.
- Invalid slave code at grant: no m_start; pulse err of the winner next cycle; go directly to GAP; m_slave stays 00.
- START: m_start=1 for exactly one cycle; go to WAIT; clear timeout counter.
- WAIT: m_done=1 -> rdata<=m_rdata, ack pulse to owner, go to GAP. Counter reaches TIMEOUT with no m_done -> err pulse to owner, go to GAP. m_done outside WAIT is ignored.
- GAP: m_slave=00; count GAP_CYCLES cycles, then go to IDLE. Requests are not sampled.
- req deassert after grant is ignored; the transaction completes. req deassert before grant withdraws the request.
- Requester must hold req, slv, dtf and wdata stable until its ack/err. It may re-request immediately after ack; the request is served after GAP.

## Timing
- Reset (async, rst=0): state IDLE. m_start, ack0/1, err0/1 and busy are 0. m_slave=00, m_dtf=00, m_wdata=0, rdata=0, owner=1. Timers cleared.
- Reset mid-transaction aborts immediately, with no ack/err. The master sees m_slave=00 at once.
- Latency: req sampled at edge N -> m_start high in cycle N+1. m_done in cycle D -> ack high in cycle D+1 -> IDLE at D+1+GAP_CYCLES -> earliest next m_start at D+GAP_CYCLES+2.
- Timeout: err in cycle N+2+TIMEOUT if no m_done.
- m_slave/m_dtf/m_wdata are stable from the m_start cycle through the last WAIT cycle.
- ack and err for the same requester are never high together. At most one of ack0/ack1/err0/err1 is high per cycle.

## Test plan
- Reset: rst=0 mid-WAIT -> all outputs go to reset values in the same cycle; no ack after rst=1.
- Single request: req0, slv0=01, dtf0=10, wdata0=8'hA5; model m_done 10 cycles after m_start with m_rdata=8'h3C -> m_slave=01, m_dtf=10, m_wdata=A5 for the transaction; ack0 and rdata=3C one cycle after m_done; next m_start no earlier than 6 cycles after m_done.
- Tie round robin: req0 and req1 held high continuously, slv1=10 -> grants alternate 0,1,0,1; m_slave alternates 01/10; m_slave is 00 during every GAP.
- Invalid slave: req1 with slv1=11 -> no m_start, err1 pulse, GAP, then IDLE.
- Timeout: m_done never asserted -> err0 exactly TIMEOUT cycles after the first WAIT cycle; a late m_done in GAP produces no ack.
- Withdraw/late drop: req1 pulsed during GAP then dropped -> never granted. req0 dropped during WAIT -> ack0 still issued.
